// File: rtl/revaluate_unit_pkg.sv
// Shared constants for the revaluation stage: slice geometry, frame size
// and FSM state encoding.
package revaluate_unit_pkg;

    localparam int SLICE_W        = 25;
    localparam int ROW_W          = 5;
    localparam int SLICES_DEFAULT = 64;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    // Lane (x, y) lives at bit 24-(5*y+x): row 0 occupies the top five bits.
    function automatic int slice_bit(input int x, input int y);
        return SLICE_W - 1 - (ROW_W * y + x);
    endfunction

endpackage

// File: rtl/revaluate_slice.sv
// Combinational per-slice transform: each row is mixed independently as
// out[x] = a[x] ^ (~a[x+1] & a[x+2]), indices mod 5.
module revaluate_slice
    import revaluate_unit_pkg::*;
(
    input  logic [SLICE_W-1:0] slice_in,
    output logic [SLICE_W-1:0] slice_out
);

    genvar gi, gj;
    generate
        for (gi = 0; gi < ROW_W; gi++) begin : g_row
            for (gj = 0; gj < ROW_W; gj++) begin : g_col
                localparam int B0 = slice_bit(gj, gi);
                localparam int B1 = slice_bit((gj + 1) % ROW_W, gi);
                localparam int B2 = slice_bit((gj + 2) % ROW_W, gi);
                assign slice_out[B0] = slice_in[B0] ^ (~slice_in[B1] & slice_in[B2]);
            end
        end
    endgenerate

endmodule

// File: rtl/revaluate_unit.sv
// Frame-level revaluation unit: accepts SLICES slices per started frame,
// transforms each and presents it through a single-entry output register.
module revaluate_unit
    import revaluate_unit_pkg::*;
#(
    parameter int SLICES = SLICES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SLICE_W-1:0] in_slice,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [SLICE_W-1:0] out_slice,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = $clog2(SLICES + 1);

    logic [1:0]         state_reg, state_next;
    logic [CNT_W-1:0]   in_cnt_reg;
    logic [SLICE_W-1:0] out_slice_reg;
    logic [SLICE_W-1:0] xform_slice;
    logic               out_valid_reg;
    logic               out_last_reg;
    logic               in_hs, out_hs, start_go;
    logic               cnt_clr, cnt_inc;

    revaluate_slice u_slice (
        .slice_in  (in_slice),
        .slice_out (xform_slice)
    );

    assign start_go = (state_reg == ST_IDLE) && start;
    assign in_ready = (state_reg == ST_RUN) && (in_cnt_reg < CNT_W'(SLICES))
                      && (!out_valid_reg || out_ready);
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid_reg && out_ready;
    assign cnt_clr  = start_go;
    assign cnt_inc  = in_hs;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (out_hs && out_last_reg) state_next = ST_FIN;
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Accepted-slice counter: start only clears it from IDLE, so a stray
    // start mid-frame cannot rewind the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_cnt_reg <= '0;
        end else if (cnt_clr) begin
            in_cnt_reg <= '0;
        end else if (cnt_inc) begin
            in_cnt_reg <= in_cnt_reg + CNT_W'(1);
        end
    end

    // A load wins over a drain so simultaneous handshakes stream bubble-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_slice_reg <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else if (in_hs) begin
            out_slice_reg <= xform_slice;
            out_valid_reg <= 1'b1;
            out_last_reg  <= (in_cnt_reg == CNT_W'(SLICES - 1));
        end else if (out_hs) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end
    end

    assign out_slice = out_slice_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign busy      = (state_reg == ST_RUN);
    assign done      = (state_reg == ST_FIN);

endmodule

// File: tb/tb_revaluate_unit.sv
// Self-checking bench for revaluate_unit: known-answer table frame plus
// randomized frames scored against a lane-level reference model.
module tb_revaluate_unit;

    localparam int NS = 64;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, out_ready;
    logic        in_ready, out_valid, out_last, busy, done;
    logic [24:0] in_slice, out_slice;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [24:0] din;
        logic [24:0] dout;
    } vec_t;
    vec_t tbl[8];

    always #5 clk = ~clk;

    revaluate_unit #(.SLICES(NS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_slice  (in_slice),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_slice (out_slice),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Lane-grid model: unpack to a 5x5 array, apply the row rule, repack.
    function automatic logic [24:0] ref_model(input logic [24:0] s);
        bit a[5][5];
        logic [24:0] r;
        r = '0;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                a[x][y] = s[24 - (5 * y + x)];
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                r[24 - (5 * y + x)] = a[x][y] ^ (!a[(x + 1) % 5][y] && a[(x + 2) % 5][y]);
        return r;
    endfunction

    task automatic run_frame(input bit use_tbl, input int gap_pct, input int bp_pct,
                             input int start_at, input int stall_at, input int abort_at);
        logic [24:0] q[$];
        logic [24:0] prev_slice, v, exp_slice;
        logic        prev_last;
        bit prev_hold = 0, last_done = 0, finished = 0, pulsed = 0, stalled = 0;
        bit exp_ready, exp_valid, ihs, ohs;
        int sent = 0, recv = 0, cyc = 0, stall_left = 0;
        int first_in = -1, first_out = -1, last_out = -1;

        @(negedge clk);
        start = 1; in_valid = 0; out_ready = 1;
        while (!finished) begin
            @(negedge clk);
            cyc++;
            start = 0;
            if (cyc > 3000) begin
                chk("frame_timeout", 1, 0);
                break;
            end
            if (last_done) begin
                in_valid = 0;
                chk("done_pulse", done, 1);
                chk("busy_in_fin", busy, 0);
                chk("in_ready_in_fin", in_ready, 0);
                @(negedge clk);
                chk("done_cleared", done, 0);
                chk("busy_idle", busy, 0);
                finished = 1;
                break;
            end
            chk("done_low_in_run", done, 0);
            chk("busy_in_run", busy, 1);
            if (abort_at >= 0 && sent == abort_at) begin
                rst = 0; in_valid = 0;
                #1;
                chk("abort_out_valid", out_valid, 0);
                chk("abort_out_slice", out_slice, 0);
                chk("abort_out_last", out_last, 0);
                chk("abort_in_ready", in_ready, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                @(negedge clk);
                rst = 1;
                repeat (3) @(negedge clk);
                chk("post_abort_busy", busy, 0);
                chk("post_abort_in_ready", in_ready, 0);
                $display("frame aborted after %0d slices", sent);
                return;
            end
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_slice", out_slice, prev_slice);
                chk("hold_last", out_last, prev_last);
            end
            if (start_at >= 0 && sent == start_at && !pulsed) begin
                start = 1; pulsed = 1;
            end
            if (stall_at >= 0 && sent == stall_at && !stalled) begin
                stalled = 1; stall_left = 5;
            end
            if (stall_left > 0) begin
                out_ready = 0; stall_left--;
            end else begin
                out_ready = ($urandom_range(99) >= bp_pct);
            end
            in_valid = ($urandom_range(99) >= gap_pct);
            v = use_tbl ? tbl[sent % 8].din : 25'($urandom);
            in_slice = v;
            #1;
            exp_valid = (q.size() != 0);
            exp_ready = (sent < NS) && (!exp_valid || out_ready);
            chk("out_valid", out_valid, exp_valid);
            chk("in_ready", in_ready, exp_ready);
            ihs = in_valid && exp_ready;
            ohs = exp_valid && out_ready;
            prev_hold  = exp_valid && !out_ready;
            prev_slice = out_slice;
            prev_last  = out_last;
            if (ohs) begin
                exp_slice = q.pop_front();
                chk("out_slice", out_slice, exp_slice);
                chk("out_last", out_last, recv == NS - 1);
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                recv++;
                if (recv == NS) last_done = 1;
            end
            if (ihs) begin
                q.push_back(use_tbl ? tbl[sent % 8].dout : ref_model(v));
                if (first_in < 0) first_in = cyc;
                sent++;
            end
        end
        if (finished && gap_pct == 0 && bp_pct == 0 && stall_at < 0) begin
            chk("latency", first_out - first_in, 1);
            chk("throughput", last_out - first_out, NS - 1);
        end
        $display("frame done: sent=%0d recv=%0d cycles=%0d", sent, recv, cyc);
    endtask

    initial begin
        tbl[0] = '{25'h1000000, 25'h1200000};
        tbl[1] = '{25'h0800000, 25'h0900000};
        tbl[2] = '{25'h0000000, 25'h0000000};
        tbl[3] = '{25'h1FFFFFF, 25'h1FFFFFF};
        tbl[4] = '{25'h0000001, 25'h0000005};
        tbl[5] = '{25'h1F00000, 25'h1F00000};
        tbl[6] = '{25'h1400000, 25'h0600000};
        tbl[7] = '{25'h0000010, 25'h0000012};

        rst = 0; start = 0; in_valid = 0; out_ready = 0; in_slice = '0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_slice", out_slice, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 1;

        // Without start the unit must ignore offered slices.
        in_valid = 1; out_ready = 1; in_slice = 25'h1234567;
        repeat (3) begin
            @(negedge clk);
            chk("idle_in_ready", in_ready, 0);
            chk("idle_out_valid", out_valid, 0);
            chk("idle_busy", busy, 0);
        end
        in_valid = 0;

        run_frame(1'b1, 0, 0, -1, -1, -1);   // known answers, full rate
        run_frame(1'b0, 30, 30, -1, -1, -1); // random gaps and backpressure
        run_frame(1'b0, 10, 0, 10, 20, -1);  // start in RUN plus 5-cycle stall
        run_frame(1'b0, 0, 0, -1, -1, 30);   // reset mid-frame
        run_frame(1'b0, 0, 0, -1, -1, -1);   // full frame after the abort

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
